led_strip_tx: RTL
=================

LED_STRIP_TX -- requirements
Module: led_strip_tx

Interface
REQ-001 SHALL have parameter T0H_CYC, default 20, high time of a 0 bit in clocks (400 ns at 50 MHz).
REQ-002 SHALL have parameter T1H_CYC, default 40, high time of a 1 bit in clocks.
REQ-003 SHALL have parameter TBIT_CYC, default 63, total bit period in clocks.
REQ-004 SHALL have parameter TRST_CYC, default 3000, end-of-frame latch low time in clocks.
REQ-005 SHALL have parameter RD_LAT, default 1, legal range 1..3, led_ram read latency in clocks.
REQ-006 clk_clk  in  1  sole clock; all logic rising-edge.
REQ-007 reset_reset_n  in  1  asynchronous active-low reset.
REQ-008 i_start  in  1  single-cycle frame request.
REQ-009 i_led_count  in  11  number of LEDs in the frame, 0..2047.
REQ-010 led_ram_address  out  11  word address of the LED being fetched.
REQ-011 led_ram_chipselect  out  1  read strobe.
REQ-012 led_ram_clken  out  1  clock enable, equal to led_ram_chipselect.
REQ-013 led_ram_write  out  1  constant 0.
REQ-014 led_ram_writedata  out  32  constant 0.
REQ-015 led_ram_byteenable  out  4  constant 4'hF.
REQ-016 led_ram_readdata  in  32  LED word; [23:16]=G, [15:8]=R, [7:0]=B; [31:24] ignored.
REQ-017 o_data  out  1  WS2812 serial line, idle low.
REQ-018 o_busy  out  1  frame in progress.
REQ-019 o_done  out  1  one-cycle pulse at frame end.

Function
REQ-020 SHALL implement FSM states IDLE, FETCH, SEND, LATCH, DONE.
REQ-021 SHALL leave IDLE only on i_start=1, latching i_led_count, and SHALL ignore i_start in all other states.
REQ-022 SHALL enter DONE directly, with no RAM access and o_data low, when the latched count is 0.
REQ-023 FETCH SHALL drive address 0 with chipselect=1 for one cycle and SHALL capture readdata exactly RD_LAT cycles later.
REQ-024 If i_start is sampled at cycle N, o_data SHALL first rise at cycle N+2+RD_LAT.
REQ-025 Bits SHALL go MSB first (word bit 23 down to 0); each bit SHALL be high for T1H_CYC (1) or T0H_CYC (0) clocks, then low until TBIT_CYC clocks total.
REQ-026 During bit 23 of LED k (k < count-1), SHALL issue exactly one read of address k+1 into a prefetch register.
REQ-027 Consecutive bits and consecutive LEDs SHALL be contiguous: no extra clocks between bit periods.
REQ-028 After the last bit of the last LED, LATCH SHALL hold o_data low for TRST_CYC clocks.
REQ-029 DONE SHALL assert o_done for one cycle and then return to IDLE.
REQ-030 o_busy SHALL be 1 from cycle N+1 through the LATCH state, and 0 in DONE and IDLE.
REQ-031 Address arithmetic SHALL be 11-bit; count 2047 SHALL reach address 2046 without wrap.
REQ-032 led_ram_chipselect SHALL be high only in the issue cycle of each read.

Reset
REQ-033 On reset_reset_n=0, the state SHALL go to IDLE immediately; o_data, o_busy, o_done, chipselect, clken and address SHALL be 0.
REQ-034 A reset mid-frame SHALL abort the frame with no o_done pulse; the next i_start SHALL begin a fresh frame at address 0.

Structure
REQ-035 Package led_strip_pkg SHALL hold the state enum, the default timing constants and the LED word field positions.
REQ-036 Sub-module led_bit_encoder SHALL generate one bit waveform from the inputs bit and go, and the output bit_end.

Verification
REQ-037 count=1, word 0x00A50F3C: 24 periods of 63 clocks; high times 40 for the pattern A50F3C 1-bits and 20 for 0-bits; then 3000 low clocks; then o_done.
REQ-038 count=2, words 0xFFFFFF and 0x000000: 48 contiguous periods with no gap at the LED boundary; exactly 2 reads at addresses 0 and 1.
REQ-039 count=0: o_done within 3 cycles, with no chipselect and o_data held low.
REQ-040 i_start pulsed mid-frame: ignored; one o_done only; read count equals i_led_count.
REQ-041 Reset asserted during bit 10 of LED 3: o_data=0 immediately and no o_done; a restart reads address 0 first.
REQ-042 RD_LAT=3, count=3: first o_data rise at N+5; periods remain contiguous.

Source files
------------

// File: rtl/led_strip_pkg.sv
// Shared definitions for the WS2812 LED strip transmitter.
// Holds the frame FSM state encoding, the default bit/latch timing
// (in clocks at 50 MHz) and the bit positions of the colour fields
// inside a 32-bit LED RAM word.
package led_strip_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SEND,
    ST_LATCH,
    ST_DONE
  } state_e;

  localparam int DEF_T0H_CYC  = 20;
  localparam int DEF_T1H_CYC  = 40;
  localparam int DEF_TBIT_CYC = 63;
  localparam int DEF_TRST_CYC = 3000;
  localparam int DEF_RD_LAT   = 1;

  // LED word layout: [23:16]=G, [15:8]=R, [7:0]=B, [31:24] unused.
  localparam int LED_BITS = 24;
  localparam int LED_MSB  = 23;
  localparam int FIELD_W  = 8;
  localparam int G_LSB    = 16;
  localparam int R_LSB    = 8;
  localparam int B_LSB    = 0;

endpackage

// File: rtl/led_bit_encoder.sv
// One WS2812 bit period generator.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   bit_i, go_i   : go_i starts a period for bit_i on this edge
//   data_o        : registered line output, high T1H/T0H clocks then low
//   bit_end_o     : high in the last clock of a period; asserting go_i
//                   in that clock makes the next period contiguous
module led_bit_encoder
  import led_strip_pkg::*;
#(
  parameter int T0H_CYC  = DEF_T0H_CYC,
  parameter int T1H_CYC  = DEF_T1H_CYC,
  parameter int TBIT_CYC = DEF_TBIT_CYC
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic bit_i,
  input  logic go_i,
  output logic data_o,
  output logic bit_end_o
);

  localparam int CW = $clog2(TBIT_CYC);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_nx;
  logic [CW-1:0] hi_len;
  logic          active_q;
  logic          bit_q;
  logic          data_q;

  // cnt_q is the index of the clock currently on the line (0..TBIT-1).
  assign cnt_nx    = cnt_q + CW'(1);
  assign hi_len    = bit_q ? CW'(T1H_CYC) : CW'(T0H_CYC);
  assign bit_end_o = active_q && (cnt_q == CW'(TBIT_CYC - 1));
  assign data_o    = data_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
      bit_q    <= 1'b0;
      data_q   <= 1'b0;
    end else if (go_i) begin
      cnt_q    <= '0;
      active_q <= 1'b1;
      bit_q    <= bit_i;
      data_q   <= 1'b1;
    end else if (active_q) begin
      if (bit_end_o) begin
        cnt_q    <= '0;
        active_q <= 1'b0;
        data_q   <= 1'b0;
      end else begin
        cnt_q  <= cnt_nx;
        data_q <= (cnt_nx < hi_len);
      end
    end
  end

endmodule

// File: rtl/led_strip_tx.sv
// WS2812 LED strip frame transmitter.
// On i_start (in IDLE) it latches i_led_count, reads one 24-bit GRB word
// per LED from an external RAM (read latency RD_LAT), shifts the bits out
// MSB first on o_data, then holds the line low for TRST_CYC clocks and
// pulses o_done.
// Ports:
//   clk_clk, reset_reset_n : clock, asynchronous active-low reset
//   i_start, i_led_count   : frame request and LED count (0..2047)
//   led_ram_*              : read-only RAM master (chipselect == clken)
//   o_data                 : serial line, idle low
//   o_busy, o_done         : frame in progress, one-cycle end pulse
//   o_dbg_state            : current FSM state for debug
// RAM handshake: a read is issued in the single cycle chipselect is high
// and its data is taken exactly RD_LAT clocks after that edge; there is
// no ready/wait signal.
module led_strip_tx
  import led_strip_pkg::*;
#(
  parameter int T0H_CYC  = DEF_T0H_CYC,
  parameter int T1H_CYC  = DEF_T1H_CYC,
  parameter int TBIT_CYC = DEF_TBIT_CYC,
  parameter int TRST_CYC = DEF_TRST_CYC,
  parameter int RD_LAT   = DEF_RD_LAT
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        i_start,
  input  logic [10:0] i_led_count,
  output logic [10:0] led_ram_address,
  output logic        led_ram_chipselect,
  output logic        led_ram_clken,
  output logic        led_ram_write,
  output logic [31:0] led_ram_writedata,
  output logic [3:0]  led_ram_byteenable,
  input  logic [31:0] led_ram_readdata,
  output logic        o_data,
  output logic        o_busy,
  output logic        o_done,
  output state_e      o_dbg_state
);

  localparam int LW = (TRST_CYC > 1) ? $clog2(TRST_CYC) : 1;

  state_e            state_q;
  logic [10:0]       count_q;
  logic [10:0]       led_idx_q;
  logic [10:0]       addr_q;
  logic [4:0]        bit_cnt_q;
  logic [LED_MSB:0]  word_q;
  logic [LED_MSB:0]  pref_q;
  logic [LW-1:0]     lat_cnt_q;
  logic [RD_LAT-1:0] rd_pipe_q;
  logic              cs_q;
  logic              busy_q;
  logic              done_q;

  logic rd_valid;
  logic is_last;
  logic bit_end;
  logic enc_go;
  logic enc_bit;
  logic unused_hi;

  assign unused_hi = ^led_ram_readdata[31:LED_BITS];

  assign led_ram_address    = addr_q;
  assign led_ram_chipselect = cs_q;
  assign led_ram_clken      = cs_q;
  assign led_ram_write      = 1'b0;
  assign led_ram_writedata  = 32'h0;
  assign led_ram_byteenable = 4'hF;
  assign o_busy             = busy_q;
  assign o_done             = done_q;
  assign o_dbg_state        = state_q;

  // Tracks each issued read; the top bit marks the edge its data is valid.
  assign rd_valid = rd_pipe_q[RD_LAT-1];
  assign is_last  = (led_idx_q == count_q - 11'd1);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) rd_pipe_q <= '0;
    else                rd_pipe_q <= (rd_pipe_q << 1) | RD_LAT'(cs_q);
  end

  // Next bit to start: first bit straight from RAM, later bits from the
  // shift register, first bit of the next LED from the prefetch register.
  always_comb begin
    enc_go  = 1'b0;
    enc_bit = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (rd_valid) begin
          enc_go  = 1'b1;
          enc_bit = led_ram_readdata[LED_MSB];
        end
      end
      ST_SEND: begin
        if (bit_end) begin
          if (bit_cnt_q != 5'd0) begin
            enc_go  = 1'b1;
            enc_bit = word_q[LED_MSB-1];
          end else if (!is_last) begin
            enc_go  = 1'b1;
            enc_bit = pref_q[LED_MSB];
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      led_idx_q <= '0;
      addr_q    <= '0;
      bit_cnt_q <= '0;
      word_q    <= '0;
      pref_q    <= '0;
      lat_cnt_q <= '0;
      cs_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      cs_q   <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            count_q   <= i_led_count;
            led_idx_q <= '0;
            addr_q    <= '0;
            if (i_led_count == 11'd0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_FETCH;
              cs_q    <= 1'b1;
              busy_q  <= 1'b1;
            end
          end
        end
        ST_FETCH: begin
          if (rd_valid) begin
            word_q    <= led_ram_readdata[LED_MSB:0];
            bit_cnt_q <= 5'(LED_MSB);
            state_q   <= ST_SEND;
            // First bit of LED 0 is starting: prefetch LED 1.
            if (count_q != 11'd1) begin
              cs_q   <= 1'b1;
              addr_q <= 11'd1;
            end
          end
        end
        ST_SEND: begin
          if (rd_valid) pref_q <= led_ram_readdata[LED_MSB:0];
          if (bit_end) begin
            if (bit_cnt_q != 5'd0) begin
              bit_cnt_q <= bit_cnt_q - 5'd1;
              word_q    <= word_q << 1;
            end else if (is_last) begin
              state_q   <= ST_LATCH;
              lat_cnt_q <= '0;
            end else begin
              word_q    <= pref_q;
              bit_cnt_q <= 5'(LED_MSB);
              led_idx_q <= led_idx_q + 11'd1;
              // Bit 23 of LED led_idx+1 starts now: prefetch led_idx+2.
              if (led_idx_q + 11'd2 < count_q) begin
                cs_q   <= 1'b1;
                addr_q <= led_idx_q + 11'd2;
              end
            end
          end
        end
        ST_LATCH: begin
          if (lat_cnt_q == LW'(TRST_CYC - 1)) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            lat_cnt_q <= lat_cnt_q + LW'(1);
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  led_bit_encoder #(
    .T0H_CYC (T0H_CYC),
    .T1H_CYC (T1H_CYC),
    .TBIT_CYC(TBIT_CYC)
  ) u_enc (
    .clk_i    (clk_clk),
    .rst_ni   (reset_reset_n),
    .bit_i    (enc_bit),
    .go_i     (enc_go),
    .data_o   (o_data),
    .bit_end_o(bit_end)
  );

endmodule
